// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with input synchroniser, break detection and
//            a single-entry valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] d_rx,
    output logic       vld_rx,
    input  logic       rdy_rx,
    output logic       err_frm,
    output logic       err_ovr,
    output logic       busy
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd_s;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [2:0]           r_idx,   w_idx_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [7:0]           r_data,  w_data_nxt;
    logic                 r_vld,   w_vld_nxt;
    logic                 r_frm,   w_frm_nxt;
    logic                 r_ovr,   w_ovr_nxt;
    logic                 w_good;

    // Line idles high, so the synchroniser resets to ones to avoid a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign w_rxd_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_frm   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_vld   <= w_vld_nxt;
            r_frm   <= w_frm_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_vld_nxt   = r_vld;
        w_frm_nxt   = 1'b0;
        w_ovr_nxt   = 1'b0;
        w_good      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                w_cnt_nxt = '0;
                // The detecting cycle is already timer value 0 of the start bit.
                if (!w_rxd_s) begin
                    if (c_HALF == '0) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            S_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_shift_nxt[r_idx] = w_rxd_s;
                    w_cnt_nxt          = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxd_s) begin
                        w_state_nxt = S_IDLE;
                        w_good      = 1'b1;
                    end else begin
                        w_state_nxt = S_BREAK;
                        w_frm_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // A byte consumed in the same cycle frees the register for the new one.
        if (w_good) begin
            if (!r_vld || rdy_rx) begin
                w_data_nxt = r_shift;
                w_vld_nxt  = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end else if (r_vld && rdy_rx) begin
            w_vld_nxt = 1'b0;
        end
    end

    assign d_rx    = r_data;
    assign vld_rx  = r_vld;
    assign err_frm = r_frm;
    assign err_ovr = r_ovr;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at 1 and 16 clks/bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd1, rxd16, rdy1, rdy16;
    logic [7:0] d1, d16;
    logic       vld1, vld16, frm1, frm16, ovr1, ovr16, busy1, busy16;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_start;
    int         rise_cyc1, vld_hi1, frm_cnt1, ovr_cnt1, frm_cnt16, ovr_cnt16;
    logic       vld1_prev;
    logic [7:0] q1[$];
    logic [7:0] q16[$];

    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .d_rx(d1), .vld_rx(vld1),
        .rdy_rx(rdy1), .err_frm(frm1), .err_ovr(ovr1), .busy(busy1)
    );

    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_dut16 (
        .clk(clk), .rst(rst), .rxd(rxd16), .d_rx(d16), .vld_rx(vld16),
        .rdy_rx(rdy16), .err_frm(frm16), .err_ovr(ovr16), .busy(busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rise_cyc1 = 0; vld_hi1 = 0; frm_cnt1 = 0; ovr_cnt1 = 0;
        frm_cnt16 = 0; ovr_cnt16 = 0; vld1_prev = 1'b0;
    end

    // Accepted bytes and error pulses are logged away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (vld1 && rdy1)   q1.push_back(d1);
            if (vld16 && rdy16) q16.push_back(d16);
            if (vld1 && !vld1_prev) rise_cyc1 = cyc;
            if (vld1)  vld_hi1   = vld_hi1 + 1;
            if (frm1)  frm_cnt1  = frm_cnt1 + 1;
            if (ovr1)  ovr_cnt1  = ovr_cnt1 + 1;
            if (frm16) frm_cnt16 = frm_cnt16 + 1;
            if (ovr16) ovr_cnt16 = ovr_cnt16 + 1;
        end
        vld1_prev = vld1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serialise one 8N1 frame; the stop level stays on the line afterwards.
    task automatic tx(input int sel, input logic [7:0] b, input logic stop);
        int         n;
        logic [9:0] fr;
        n  = (sel == 1) ? 1 : 16;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (sel == 1) rxd1 = fr[i];
            else          rxd16 = fr[i];
            if (i == 0) last_start = cyc;
            repeat (n - 1) @(posedge clk);
        end
    endtask

    initial begin
        int b, h0, f0, o0;
        rst = 1'b1; rxd1 = 1'b1; rxd16 = 1'b1; rdy1 = 1'b1; rdy16 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_d1", d1, 8'h00);
        check("rst_vld1", vld1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_err1", {frm1, ovr1}, 0);
        check("rst_vld16", vld16, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Single frame: latency and one-cycle valid
        b = q1.size(); h0 = vld_hi1; f0 = frm_cnt1; o0 = ovr_cnt1;
        tx(1, 8'h5A, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t1_count", q1.size() - b, 1);
        if (q1.size() > b) check("t1_byte", q1[b], 8'h5A);
        check("t1_latency", rise_cyc1 - last_start, 12);
        check("t1_vld_cycles", vld_hi1 - h0, 1);
        check("t1_errs", (frm_cnt1 - f0) + (ovr_cnt1 - o0), 0);

        // Back-to-back frames
        b = q1.size(); f0 = frm_cnt1; o0 = ovr_cnt1;
        tx(1, 8'h00, 1'b1);
        tx(1, 8'hFF, 1'b1);
        tx(1, 8'hA5, 1'b1);
        tx(1, 8'h3C, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t2_count", q1.size() - b, 4);
        if (q1.size() >= b + 4) begin
            check("t2_b0", q1[b],   8'h00);
            check("t2_b1", q1[b+1], 8'hFF);
            check("t2_b2", q1[b+2], 8'hA5);
            check("t2_b3", q1[b+3], 8'h3C);
        end
        check("t2_errs", (frm_cnt1 - f0) + (ovr_cnt1 - o0), 0);

        // Framing error followed by a held-low line
        b = q1.size(); f0 = frm_cnt1;
        tx(1, 8'h81, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t4_frm_pulses", frm_cnt1 - f0, 1);
        check("t4_busy_break", busy1, 1);
        check("t4_no_vld", vld1, 0);
        check("t4_no_byte", q1.size() - b, 0);
        @(posedge clk); #1 rxd1 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_idle", busy1, 0);
        tx(1, 8'h42, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t4_next_count", q1.size() - b, 1);
        if (q1.size() > b) check("t4_next_byte", q1[b], 8'h42);
        check("t4_frm_total", frm_cnt1 - f0, 1);

        // Glitch on the slow receiver
        f0 = frm_cnt16; o0 = ovr_cnt16;
        @(posedge clk); #1 rxd16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd16 = 1'b1;
        @(negedge clk);
        check("t5_busy_start", busy16, 1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t5_idle", busy16, 0);
        check("t5_no_vld", vld16, 0);
        check("t5_errs", (frm_cnt16 - f0) + (ovr_cnt16 - o0), 0);

        // Overrun with consumer stalled
        b = q16.size(); o0 = ovr_cnt16;
        tx(16, 8'h11, 1'b1);
        tx(16, 8'h22, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t3_data_kept", d16, 8'h11);
        check("t3_vld", vld16, 1);
        check("t3_ovr_pulses", ovr_cnt16 - o0, 1);
        check("t3_frm", frm_cnt16 - f0, 0);
        @(posedge clk); #1 rdy16 = 1'b1;
        @(posedge clk); #1 rdy16 = 1'b0;
        @(negedge clk);
        check("t3_vld_clear", vld16, 0);
        check("t3_count", q16.size() - b, 1);
        if (q16.size() > b) check("t3_byte", q16[b], 8'h11);

        // Consume in exactly the good-stop cycle of the next frame
        b = q16.size(); o0 = ovr_cnt16;
        tx(16, 8'h33, 1'b1);
        fork
            tx(16, 8'h44, 1'b1);
            begin
                @(posedge clk);
                repeat (153) @(posedge clk);
                #1 rdy16 = 1'b1;
                @(posedge clk);
                #1 rdy16 = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5s_data", d16, 8'h44);
        check("t5s_vld", vld16, 1);
        check("t5s_no_ovr", ovr_cnt16 - o0, 0);
        check("t5s_count", q16.size() - b, 1);
        if (q16.size() > b) check("t5s_first", q16[b], 8'h33);
        @(posedge clk); #1 rdy16 = 1'b1;
        @(posedge clk); #1 rdy16 = 1'b0;
        @(negedge clk);
        check("t5s_drain", vld16, 0);

        // Reset in the middle of a frame
        f0 = frm_cnt1; o0 = ovr_cnt1; b = q1.size();
        @(posedge clk); #1 rxd1 = 1'b0;
        @(posedge clk); #1 rxd1 = 1'b1;
        @(posedge clk); #1 rxd1 = 1'b1;
        @(posedge clk); #1 rxd1 = 1'b0;
        @(posedge clk); #1 rxd1 = 1'b0;
        @(posedge clk); #1 rst = 1'b1; rxd1 = 1'b1;
        @(negedge clk);
        check("t6_busy_pre", busy1, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_d1", d1, 8'h00);
        check("t6_vld1", vld1, 0);
        check("t6_busy1", busy1, 0);
        check("t6_err1", {frm1, ovr1}, 0);
        check("t6_d16", d16, 8'h00);
        tx(1, 8'hC3, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_count", q1.size() - b, 1);
        if (q1.size() > b) check("t6_byte", q1[b], 8'hC3);
        check("t6_errs", (frm_cnt1 - f0) + (ovr_cnt1 - o0), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
